// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl bus bundle: UART RX bytes, register file,
// ALU and UART TX parallel handshake.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int FUN_WIDTH     = 4
);
  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [ADDR_WIDTH-1:0]    RF_Address;
  logic                     RF_WrEn;
  logic                     RF_RdEn;
  logic [DATA_WIDTH-1:0]    RF_WrData;
  logic [DATA_WIDTH-1:0]    RF_RdData;
  logic                     RF_RdData_Valid;
  logic                     ALU_EN;
  logic [FUN_WIDTH-1:0]     ALU_FUN;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     ALU_OUT_Valid;
  logic                     CLK_GATE_EN;
  logic [ALU_OUT_WIDTH-1:0] TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     TX_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD,
    input  RF_RdData, RF_RdData_Valid,
    input  ALU_OUT, ALU_OUT_Valid,
    input  TX_BUSY,
    output RF_Address, RF_WrEn, RF_RdEn,
    output RF_WrData, ALU_EN, ALU_FUN,
    output CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD,
    output RF_RdData, RF_RdData_Valid,
    output ALU_OUT, ALU_OUT_Valid,
    output TX_BUSY,
    input  RF_Address, RF_WrEn, RF_RdEn,
    input  RF_WrData, ALU_EN, ALU_FUN,
    input  CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Host command frame decoder driving the register file and ALU,
// returning results to the UART TX parallel port.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int FUN_WIDTH     = 4
) (
  input  logic           CLK,
  input  logic           RST,
  sys_cmd_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_OP_A     = 4'd5;
  localparam logic [3:0] S_OP_B     = 4'd6;
  localparam logic [3:0] S_ALU_FUN  = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_WAIT  = 4'd9;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = 8'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = 8'hBB;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = 8'hCC;
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = 8'hDD;

  localparam int PAD = ALU_OUT_WIDTH - DATA_WIDTH;

  logic [3:0] state;
  logic       vld;

  assign vld = bus.RX_D_VLD;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= S_IDLE;
      bus.RF_Address  <= '0;
      bus.RF_WrEn     <= 1'b0;
      bus.RF_RdEn     <= 1'b0;
      bus.RF_WrData   <= '0;
      bus.ALU_EN      <= 1'b0;
      bus.ALU_FUN     <= '0;
      bus.CLK_GATE_EN <= 1'b0;
      bus.TX_P_DATA   <= '0;
      bus.TX_D_VLD    <= 1'b0;
    end else begin
      bus.RF_WrEn  <= 1'b0;
      bus.RF_RdEn  <= 1'b0;
      bus.ALU_EN   <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vld) begin
            case (bus.RX_P_DATA)
              CMD_WR:  state <= S_WR_ADDR;
              CMD_RD:  state <= S_RD_ADDR;
              CMD_ALU: begin
                state           <= S_OP_A;
                bus.CLK_GATE_EN <= 1'b1;
              end
              CMD_FUN: begin
                state           <= S_ALU_FUN;
                bus.CLK_GATE_EN <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_WR_ADDR: begin
          if (vld) begin
            bus.RF_Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state          <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (vld) begin
            bus.RF_WrData <= bus.RX_P_DATA;
            bus.RF_WrEn   <= 1'b1;
            state         <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (vld) begin
            bus.RF_Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            bus.RF_RdEn    <= 1'b1;
            state          <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (bus.RF_RdData_Valid) begin
            bus.TX_P_DATA <= {{PAD{1'b0}}, bus.RF_RdData};
            state         <= S_TX_WAIT;
          end
        end
        // operands land in fixed RF slots 0 and 1
        S_OP_A: begin
          if (vld) begin
            bus.RF_Address <= ADDR_WIDTH'(0);
            bus.RF_WrData  <= bus.RX_P_DATA;
            bus.RF_WrEn    <= 1'b1;
            state          <= S_OP_B;
          end
        end
        S_OP_B: begin
          if (vld) begin
            bus.RF_Address <= ADDR_WIDTH'(1);
            bus.RF_WrData  <= bus.RX_P_DATA;
            bus.RF_WrEn    <= 1'b1;
            state          <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (vld) begin
            bus.ALU_FUN <= bus.RX_P_DATA[FUN_WIDTH-1:0];
            bus.ALU_EN  <= 1'b1;
            state       <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (bus.ALU_OUT_Valid) begin
            bus.TX_P_DATA   <= bus.ALU_OUT;
            bus.CLK_GATE_EN <= 1'b0;
            state           <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (!bus.TX_BUSY) begin
            bus.TX_D_VLD <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: RF/ALU responders,
// expected strobes and TX words queued per frame.
module tb_sys_cmd_ctrl;

  logic clk;
  logic rst_n;

  sys_cmd_ctrl_if bus ();

  sys_cmd_ctrl dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [15:0] tx_q[$];

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int alu_cnt  = 0;
  int tx_cnt   = 0;
  int gate_drop = 0;
  bit gate_watch = 0;

  logic [7:0]  rd_resp;
  logic [15:0] alu_resp;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return {27'd0, bus.RF_Address, bus.RF_WrEn, bus.RF_RdEn,
            bus.RF_WrData, bus.ALU_EN, bus.ALU_FUN,
            bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RF_WrEn || bus.RF_RdEn)
        chk("wr_rd_excl", 64'(bus.RF_WrEn & bus.RF_RdEn), 0);
      if (bus.RF_WrEn) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexp", 1, 0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 64'(bus.RF_Address), 64'(e.a));
          chk("wr_data", 64'(bus.RF_WrData), 64'(e.d));
        end
      end
      if (bus.RF_RdEn) begin
        rd_cnt++;
        if (rd_q.size() == 0) chk("rd_unexp", 1, 0);
        else chk("rd_addr", 64'(bus.RF_Address), 64'(rd_q.pop_front()));
      end
      if (bus.ALU_EN) begin
        alu_cnt++;
        if (alu_q.size() == 0) chk("alu_unexp", 1, 0);
        else chk("alu_fun", 64'(bus.ALU_FUN), 64'(alu_q.pop_front()));
      end
      if (bus.TX_D_VLD) begin
        tx_cnt++;
        if (tx_q.size() == 0) chk("tx_unexp", 1, 0);
        else chk("tx_data", 64'(bus.TX_P_DATA), 64'(tx_q.pop_front()));
      end
      if (gate_watch) begin
        if (!bus.CLK_GATE_EN) gate_drop++;
        if (bus.ALU_OUT_Valid) gate_watch = 0;
      end
    end
  end

  // register-file read responder
  always @(negedge clk) begin
    if (rst_n && bus.RF_RdEn) begin
      repeat (3) @(posedge clk);
      #1;
      bus.RF_RdData       = rd_resp;
      bus.RF_RdData_Valid = 1'b1;
      @(posedge clk);
      #1;
      bus.RF_RdData_Valid = 1'b0;
    end
  end

  // ALU responder
  always @(negedge clk) begin
    if (rst_n && bus.ALU_EN) begin
      repeat (3) @(posedge clk);
      #1;
      bus.ALU_OUT       = alu_resp;
      bus.ALU_OUT_Valid = 1'b1;
      @(posedge clk);
      #1;
      bus.ALU_OUT_Valid = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge clk);
    #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int start, input string tag);
    int k;
    k = 0;
    while (tx_cnt == start && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (tx_cnt == start) chk(tag, 0, 1);
  endtask

  int t0, w0;
  logic [63:0] s0;

  initial begin
    rst_n               = 1'b0;
    bus.RX_P_DATA       = '0;
    bus.RX_D_VLD        = 1'b0;
    bus.RF_RdData       = '0;
    bus.RF_RdData_Valid = 1'b0;
    bus.ALU_OUT         = '0;
    bus.ALU_OUT_Valid   = 1'b0;
    bus.TX_BUSY         = 1'b0;
    rd_resp             = '0;
    alu_resp            = '0;
    idle(3);
    chk("reset_outs", snap(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // write then read back
    wr_q.push_back('{a: 4'h5, d: 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    idle(3);
    chk("wr_done", 64'(wr_q.size()), 0);
    rd_resp = 8'h3C;
    rd_q.push_back(4'h5);
    tx_q.push_back(16'h003C);
    t0 = tx_cnt;
    send(8'hBB); send(8'h05);
    wait_tx(t0, "rd_tx_timeout");
    idle(4);
    chk("rd_tx_once", 64'(tx_cnt - t0), 1);

    // ALU with operands
    wr_q.push_back('{a: 4'h0, d: 8'h0A});
    wr_q.push_back('{a: 4'h1, d: 8'h03});
    alu_q.push_back(4'h0);
    alu_resp = 16'h000D;
    tx_q.push_back(16'h000D);
    t0 = tx_cnt;
    send(8'hCC);
    gate_watch = 1;
    send(8'h0A); send(8'h03); send(8'h00);
    wait_tx(t0, "alu_tx_timeout");
    idle(2);
    chk("gate_held", 64'(gate_drop), 0);
    chk("gate_off", 64'(bus.CLK_GATE_EN), 0);
    chk("alu_wr_done", 64'(wr_q.size()), 0);

    // ALU without operands
    w0 = wr_cnt;
    alu_q.push_back(4'h2);
    alu_resp = 16'h001E;
    tx_q.push_back(16'h001E);
    t0 = tx_cnt;
    send(8'hDD);
    chk("gate_on_dd", 64'(bus.CLK_GATE_EN), 1);
    send(8'h02);
    wait_tx(t0, "dd_tx_timeout");
    idle(2);
    chk("dd_no_wr", 64'(wr_cnt - w0), 0);

    // TX busy handshake
    bus.TX_BUSY = 1'b1;
    rd_resp = 8'h77;
    rd_q.push_back(4'h9);
    tx_q.push_back(16'h0077);
    t0 = tx_cnt;
    send(8'hBB); send(8'h09);
    idle(8);
    idle(20);
    chk("busy_no_vld", 64'(tx_cnt - t0), 0);
    @(posedge clk);
    #1 bus.TX_BUSY = 1'b0;
    wait_tx(t0, "busy_tx_timeout");
    idle(4);
    chk("busy_one_vld", 64'(tx_cnt - t0), 1);

    // illegal byte in IDLE
    s0 = snap();
    w0 = wr_cnt + rd_cnt + alu_cnt + tx_cnt;
    send(8'h55);
    idle(4);
    chk("illegal_outs", snap(), s0);
    chk("illegal_strb", 64'(wr_cnt + rd_cnt + alu_cnt + tx_cnt), 64'(w0));

    // byte dropped during RD_WAIT
    rd_resp = 8'hA5;
    rd_q.push_back(4'h3);
    tx_q.push_back(16'h00A5);
    t0 = tx_cnt;
    send(8'hBB); send(8'h03);
    send(8'hAA);
    wait_tx(t0, "drop_tx_timeout");
    idle(2);
    wr_q.push_back('{a: 4'h6, d: 8'h11});
    w0 = wr_cnt;
    send(8'hAA); send(8'h06); send(8'h11);
    idle(3);
    chk("after_drop_wr", 64'(wr_cnt - w0), 1);

    // reset mid-frame
    w0 = wr_cnt;
    send(8'hAA); send(8'h07);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", snap(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    chk("midrst_no_wr", 64'(wr_cnt - w0), 0);
    rd_resp = 8'h5A;
    rd_q.push_back(4'h7);
    tx_q.push_back(16'h005A);
    t0 = tx_cnt;
    send(8'hBB); send(8'h07);
    wait_tx(t0, "post_rst_tx_timeout");
    idle(3);

    chk("q_wr_empty", 64'(wr_q.size()), 0);
    chk("q_rd_empty", 64'(rd_q.size()), 0);
    chk("q_alu_empty", 64'(alu_q.size()), 0);
    chk("q_tx_empty", 64'(tx_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
